// File: rtl/key_stack_tracker_if.sv
// Keycode event input and held-key stack outputs for key_stack_tracker.
// KEYSTACK_CHANGE_EN adds the key_changed output.
interface key_stack_tracker_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                         key_valid;
    logic [WIDTH-1:0]             keyCode;
    logic                         keypress;
    logic [WIDTH-1:0]             key_top;
    logic [WIDTH-1:0]             key_prev;
    logic [DEPTH-1:0][WIDTH-1:0]  keys_flat;
    logic [CW-1:0]                held_count;
    logic                         overflow;
    logic                         stray_break;
`ifdef KEYSTACK_CHANGE_EN
    logic                         key_changed;
`endif

    modport master (
`ifdef KEYSTACK_CHANGE_EN
        input  key_changed,
`endif
        output key_valid, keyCode, keypress,
        input  key_top, key_prev, keys_flat, held_count, overflow, stray_break
    );

    modport slave (
`ifdef KEYSTACK_CHANGE_EN
        output key_changed,
`endif
        input  key_valid, keyCode, keypress,
        output key_top, key_prev, keys_flat, held_count, overflow, stray_break
    );
endinterface

// File: rtl/key_stack_tracker.sv
// Most-recent-first stack of held PS/2 keys with repeat, overflow and stray-break handling.
// Optional key_changed output is enabled by defining KEYSTACK_CHANGE_EN.
module key_stack_slot #(
    parameter int WIDTH = 8
) (
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_above,
    input  logic [WIDTH-1:0] i_below,
    output logic [WIDTH-1:0] o_next
);
    always_comb begin
        o_next = i_cur;
        if (i_push)
            o_next = i_above;
        else if (i_pop && i_shift)
            o_next = i_below;
    end
endmodule

module key_stack_tracker #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    key_stack_tracker_if.slave    ifc
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] r_stack;
    logic [DEPTH-1:0][WIDTH-1:0] w_next;
    logic [CW-1:0]               r_count;
    logic                        r_overflow;
    logic                        r_stray;
    logic [DEPTH-1:0]            w_match;
    logic [DEPTH-1:0]            w_ge;
    logic                        w_ev;
    logic                        w_hit;
    logic                        w_full;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_stray;

    // Empty slots hold 0 and code 0 never reaches an event, so a plain compare is safe.
    assign w_ev    = ifc.key_valid && (ifc.keyCode != '0);
    assign w_hit   = |w_match;
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = w_ev && ifc.keypress && !w_hit;
    assign w_pop   = w_ev && !ifc.keypress && w_hit;
    assign w_stray = w_ev && !ifc.keypress && !w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [WIDTH-1:0] w_above;
            logic [WIDTH-1:0] w_below;

            assign w_match[gi] = (r_stack[gi] == ifc.keyCode);

            // w_ge marks slots at or below the released key; those pull from beneath.
            if (gi == 0) begin : g_first
                assign w_ge[gi] = w_match[gi];
                assign w_above  = ifc.keyCode;
            end else begin : g_rest
                assign w_ge[gi] = w_ge[gi-1] | w_match[gi];
                assign w_above  = r_stack[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_last
                assign w_below = '0;
            end else begin : g_mid
                assign w_below = r_stack[gi+1];
            end

            key_stack_slot #(.WIDTH(WIDTH)) u_slot (
                .i_push  (w_push),
                .i_pop   (w_pop),
                .i_shift (w_ge[gi]),
                .i_cur   (r_stack[gi]),
                .i_above (w_above),
                .i_below (w_below),
                .o_next  (w_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stack    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_stray    <= 1'b0;
        end else begin
            r_stack    <= w_next;
            r_overflow <= w_push && w_full;
            r_stray    <= w_stray;
            if (w_push && !w_full)
                r_count <= r_count + CW'(1);
            else if (w_pop)
                r_count <= r_count - CW'(1);
        end
    end

`ifdef KEYSTACK_CHANGE_EN
    logic r_changed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_changed <= 1'b0;
        else
            r_changed <= (w_next[0] != r_stack[0]);
    end

    assign ifc.key_changed = r_changed;
`endif

    assign ifc.key_top     = r_stack[0];
    assign ifc.key_prev    = r_stack[1];
    assign ifc.keys_flat   = r_stack;
    assign ifc.held_count  = r_count;
    assign ifc.overflow    = r_overflow;
    assign ifc.stray_break = r_stray;
endmodule

// File: tb/tb_key_stack_tracker.sv
// Self-checking bench for key_stack_tracker: directed scenarios plus random events vs a queue model.
module tb_key_stack_tracker;
    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    key_stack_tracker_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) ifc ();

    key_stack_tracker #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .ifc     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of held keys, index 0 = most recent.
    logic [WIDTH-1:0] q[$];
    logic             exp_ovf;
    logic             exp_stray;
    logic             exp_chg;

    function automatic logic [DEPTH*WIDTH-1:0] exp_flat();
        logic [DEPTH*WIDTH-1:0] f;
        f = '0;
        for (int i = 0; i < q.size(); i++) f[i*WIDTH +: WIDTH] = q[i];
        return f;
    endfunction

    function automatic logic [WIDTH-1:0] exp_at(int i);
        return (i < q.size()) ? q[i] : '0;
    endfunction

    task automatic model_event(input logic [WIDTH-1:0] code, input logic press);
        int idx;
        logic [WIDTH-1:0] old_top;
        old_top   = exp_at(0);
        exp_ovf   = 1'b0;
        exp_stray = 1'b0;
        if (code != 0) begin
            idx = -1;
            for (int i = 0; i < q.size(); i++) if (q[i] == code) idx = i;
            if (press) begin
                if (idx < 0) begin
                    q.push_front(code);
                    if (q.size() > DEPTH) begin
                        void'(q.pop_back());
                        exp_ovf = 1'b1;
                    end
                end
            end else begin
                if (idx >= 0) q.delete(idx);
                else exp_stray = 1'b1;
            end
        end
        exp_chg = (exp_at(0) != old_top);
    endtask

    // Drive one event, update the model, and leave the bench 1 time unit after the capturing edge.
    task automatic send(input logic [WIDTH-1:0] code, input logic press);
        @(negedge clk);
        ifc.key_valid = 1'b1;
        ifc.keyCode   = code;
        ifc.keypress  = press;
        model_event(code, press);
        @(posedge clk);
        #1;
        ifc.key_valid = 1'b0;
        ifc.keyCode   = '0;
        ifc.keypress  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        exp_ovf = 0; exp_stray = 0; exp_chg = 0;
    endtask

    task automatic test_reset();
        ifc.key_valid = 1'b0; ifc.keyCode = '0; ifc.keypress = 1'b0;
        do_reset();
        n_total++;
        if (ifc.keys_flat !== '0 || ifc.held_count !== '0 || ifc.overflow !== 1'b0 ||
            ifc.stray_break !== 1'b0 || ifc.key_top !== '0)
            $display("FAIL reset_state: flat=%h cnt=%0d ovf=%b stray=%b, want all 0",
                     ifc.keys_flat, ifc.held_count, ifc.overflow, ifc.stray_break);
        else n_pass++;
    endtask

    task automatic test_single();
        send(8'h1D, 1);
        n_total++;
        if (ifc.key_top !== 8'h1D || ifc.key_prev !== 8'h00 || ifc.held_count !== CW'(1))
            $display("FAIL single_make: top=%h prev=%h cnt=%0d, want 1d 00 1",
                     ifc.key_top, ifc.key_prev, ifc.held_count);
        else n_pass++;
        send(8'h1D, 0);
        n_total++;
        if (ifc.key_top !== 8'h00 || ifc.held_count !== CW'(0) || ifc.stray_break !== 1'b0)
            $display("FAIL single_break: top=%h cnt=%0d stray=%b, want 00 0 0",
                     ifc.key_top, ifc.held_count, ifc.stray_break);
        else n_pass++;
    endtask

    task automatic test_middle_break();
        send(8'h1D, 1); send(8'h1C, 1); send(8'h1B, 1);
        send(8'h1C, 0);
        n_total++;
        if (ifc.key_top !== 8'h1B || ifc.key_prev !== 8'h1D || ifc.held_count !== CW'(2) ||
            ifc.stray_break !== 1'b0 || ifc.keys_flat !== 32'h0000_1D1B)
            $display("FAIL middle_break: flat=%h cnt=%0d stray=%b, want 00001d1b 2 0",
                     ifc.keys_flat, ifc.held_count, ifc.stray_break);
        else n_pass++;
        send(8'h1B, 0); send(8'h1D, 0);
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] codes [5];
        codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29};
        for (int i = 0; i < 4; i++) begin
            send(codes[i], 1);
            n_total++;
            if (ifc.overflow !== 1'b0)
                $display("FAIL ovf_early: push %0d ovf=%b, want 0", i, ifc.overflow);
            else n_pass++;
        end
        send(codes[4], 1);
        n_total++;
        if (ifc.overflow !== 1'b1 || ifc.keys_flat !== 32'h1C1B_2329 || ifc.held_count !== CW'(4))
            $display("FAIL ovf_push: ovf=%b flat=%h cnt=%0d, want 1 1c1b2329 4",
                     ifc.overflow, ifc.keys_flat, ifc.held_count);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (ifc.overflow !== 1'b0 || ifc.keys_flat !== 32'h1C1B_2329)
            $display("FAIL ovf_pulse_end: ovf=%b flat=%h, want 0 1c1b2329", ifc.overflow, ifc.keys_flat);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_repeat();
        send(8'h1D, 1); send(8'h1D, 1); send(8'h1C, 1); send(8'h1D, 1);
        n_total++;
        if (ifc.keys_flat !== 32'h0000_1D1C || ifc.held_count !== CW'(2) || ifc.overflow !== 1'b0)
            $display("FAIL repeat_noreorder: flat=%h cnt=%0d, want 00001d1c 2",
                     ifc.keys_flat, ifc.held_count);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_stray();
        send(8'h23, 0);
        n_total++;
        if (ifc.stray_break !== 1'b1 || ifc.keys_flat !== '0 || ifc.held_count !== CW'(0))
            $display("FAIL stray_empty: stray=%b flat=%h cnt=%0d, want 1 0 0",
                     ifc.stray_break, ifc.keys_flat, ifc.held_count);
        else n_pass++;
        send(8'h00, 1);
        n_total++;
        if (ifc.stray_break !== 1'b0 || ifc.overflow !== 1'b0 || ifc.keys_flat !== '0 ||
            ifc.held_count !== CW'(0))
            $display("FAIL zero_code: stray=%b ovf=%b flat=%h cnt=%0d, want 0 0 0 0",
                     ifc.stray_break, ifc.overflow, ifc.keys_flat, ifc.held_count);
        else n_pass++;
        send(8'h00, 0);
        n_total++;
        if (ifc.stray_break !== 1'b0)
            $display("FAIL zero_break: stray=%b, want 0", ifc.stray_break);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        send(8'h1D, 1); send(8'h1C, 1); send(8'h1B, 1);
        n_total++;
        if (ifc.held_count !== CW'(3))
            $display("FAIL pre_reset_count: cnt=%0d, want 3", ifc.held_count);
        else n_pass++;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (ifc.keys_flat !== '0 || ifc.held_count !== '0 || ifc.key_top !== '0 || ifc.key_prev !== '0)
            $display("FAIL async_reset: flat=%h cnt=%0d, want 0 0", ifc.keys_flat, ifc.held_count);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
`ifdef KEYSTACK_CHANGE_EN
        n_total++;
        if (ifc.key_changed !== 1'b0)
            $display("FAIL chg_reset: key_changed=%b, want 0", ifc.key_changed);
        else n_pass++;
        send(8'h1D, 1);
        n_total++;
        if (ifc.key_changed !== 1'b1)
            $display("FAIL chg_make: key_changed=%b, want 1", ifc.key_changed);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (ifc.key_changed !== 1'b0)
            $display("FAIL chg_one_cycle: key_changed=%b, want 0", ifc.key_changed);
        else n_pass++;
        send(8'h1D, 1);
        n_total++;
        if (ifc.key_changed !== 1'b0)
            $display("FAIL chg_repeat: key_changed=%b, want 0", ifc.key_changed);
        else n_pass++;
`endif
        do_reset();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] code;
        logic             press;
        for (int n = 0; n < 400; n++) begin
            code  = ($urandom_range(0, 15) == 0) ? 8'h00 : WIDTH'($urandom_range(1, 7));
            press = ($urandom_range(0, 99) < 55);
            send(code, press);
            n_total++;
            if (ifc.keys_flat !== exp_flat() || ifc.held_count !== CW'(q.size()) ||
                ifc.key_top !== exp_at(0) || ifc.key_prev !== exp_at(1) ||
                ifc.overflow !== exp_ovf || ifc.stray_break !== exp_stray
`ifdef KEYSTACK_CHANGE_EN
                || ifc.key_changed !== exp_chg
`endif
                )
                $display("FAIL random_%0d: ev=%h/%b flat=%h cnt=%0d ovf=%b stray=%b, want flat=%h cnt=%0d ovf=%b stray=%b",
                         n, code, press, ifc.keys_flat, ifc.held_count, ifc.overflow, ifc.stray_break,
                         exp_flat(), q.size(), exp_ovf, exp_stray);
            else n_pass++;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                n_total++;
                if (ifc.keys_flat !== exp_flat() || ifc.overflow !== 1'b0 || ifc.stray_break !== 1'b0)
                    $display("FAIL idle_hold_%0d: flat=%h ovf=%b stray=%b, want flat=%h 0 0",
                             n, ifc.keys_flat, ifc.overflow, ifc.stray_break, exp_flat());
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_middle_break();
        test_overflow();
        test_repeat();
        test_stray();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
